uart_rx_param: RTL and testbench

- Parametrised UART receiver; the next generation of the fixed 8N1 receive path inside the uart block.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- Adds a glitch-rejecting start detect, majority-vote bit sampling, parity/framing/overrun error reporting, and a valid/ready output handshake.
- Sits between the asynchronous serial input pin and the system-side consumer (FIFO or command decoder) in the sys_clk domain.

---
 rtl/uart_rx_param.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: glitch-rejecting start detect, 3-sample majority vote,
// optional parity, 1/2 stop bits, parity/framing/overrun flags and a valid/ready output.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 19200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstH,
    input  logic                 uart_REC_dataH,
    output logic [DATA_BITS-1:0] rx_dataH,
    output logic                 rx_validH,
    input  logic                 rx_readyH,
    output logic                 parity_errH,
    output logic                 frame_errH,
    output logic                 overrun_errH,
    output logic                 busyH
);

    localparam int DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_SAMP_A = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_SAMP_B = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  OS_SAMP_C = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT
    } state_t;

    state_t                 r_state;
    state_t                 r_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_sync3;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [OS_W-1:0]        r_os_cnt;
    logic [3:0]             r_bit_cnt;
    logic [1:0]             r_samp;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_frame_pend;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_ovr;

    logic                   w_start;
    logic                   w_tick;
    logic                   w_bit_end;
    logic                   w_maj_pt;
    logic                   w_maj;
    logic                   w_par_exp;
    logic                   w_done;
    logic                   w_frame_err;

    always_ff @(posedge sys_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= uart_REC_dataH;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_start     = (r_state == S_IDLE) && r_sync3 && !r_sync2;
    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_bit_end   = w_tick && (r_os_cnt == OS_LAST);
    assign w_maj_pt    = w_tick && (r_os_cnt == OS_SAMP_C);
    assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);
    assign w_par_exp   = (PARITY == 2) ? (^r_shift) : ~(^r_shift);
    assign w_done      = (r_state == S_STOP) && w_maj_pt && (r_bit_cnt == STOP_LAST);
    assign w_frame_err = r_frame_pend | ~w_maj;

    // Tick divider restarts on the start edge so every sample lands at a fixed bit phase
    always_ff @(posedge sys_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
        end else begin
            if (w_start || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_start || (r_state == S_IDLE) || (r_state == S_WAIT)) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= w_bit_end ? '0 : r_os_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) r_next = S_START;
            S_START: begin
                if (w_maj_pt && w_maj) begin
                    r_next = S_IDLE;
                end else if (w_bit_end) begin
                    r_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == DATA_LAST)) begin
                    r_next = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR:   if (w_bit_end) r_next = S_STOP;
            S_STOP:  if (w_done) r_next = w_frame_err ? S_WAIT : S_IDLE;
            S_WAIT:  if (r_sync2) r_next = S_IDLE;
            default: r_next = S_IDLE;
        endcase
    end

    // Bit counter restarts on every state change; it counts data bits or stop bits
    always_ff @(posedge sys_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            r_bit_cnt    <= '0;
            r_par_err    <= 1'b0;
            r_frame_pend <= 1'b0;
        end else begin
            if (r_next != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_start) begin
                r_par_err    <= 1'b0;
                r_frame_pend <= 1'b0;
            end else begin
                if ((r_state == S_PAR) && w_maj_pt) r_par_err <= w_maj ^ w_par_exp;
                if ((r_state == S_STOP) && w_maj_pt && !w_maj) r_frame_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_tick && (r_os_cnt == OS_SAMP_A)) r_samp[0] <= r_sync2;
        if (w_tick && (r_os_cnt == OS_SAMP_B)) r_samp[1] <= r_sync2;
        if ((r_state == S_DATA) && w_maj_pt) begin
            r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        end
    end

    // A completed word is dropped (with an overrun pulse) only while the held word is unconsumed
    always_ff @(posedge sys_clk or posedge sys_rstH) begin
        if (sys_rstH) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_done) begin
                if (!r_valid || rx_readyH) begin
                    r_data  <= r_shift;
                    r_perr  <= r_par_err;
                    r_ferr  <= w_frame_err;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (rx_readyH) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_dataH     = r_data;
    assign rx_validH    = r_valid;
    assign parity_errH  = r_perr;
    assign frame_errH   = r_ferr;
    assign overrun_errH = r_ovr;
    assign busyH        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: serial frames in, expected words queued from frame contents.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD       = 3_125_000;
    localparam int DATA_BITS  = 8;
    localparam int PARITY     = 2;
    localparam int STOP_BITS  = 2;
    localparam int OVERSAMPLE = 8;
    localparam int BIT_CYC    = CLK_FREQ / BAUD;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 line;
    logic                 rx_readyH;
    logic [DATA_BITS-1:0] rx_dataH;
    logic                 rx_validH;
    logic                 parity_errH;
    logic                 frame_errH;
    logic                 overrun_errH;
    logic                 busyH;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ovr_seen = 0;
    int   ovr_exp  = 0;
    bit   rand_ready = 1'b0;
    logic ready_force = 1'b1;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DATA_BITS),
        .PARITY(PARITY), .STOP_BITS(STOP_BITS), .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .sys_clk(clk), .sys_rstH(rst), .uart_REC_dataH(line),
        .rx_dataH(rx_dataH), .rx_validH(rx_validH), .rx_readyH(rx_readyH),
        .parity_errH(parity_errH), .frame_errH(frame_errH),
        .overrun_errH(overrun_errH), .busyH(busyH)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        line = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int nbits);
        repeat (nbits) send_bit(1'b1);
    endtask

    // Even parity: a correct parity bit makes the count of ones over data+parity even
    task automatic send_frame(input logic [7:0] d, input logic par_ok, input logic s0, input logic s1);
        logic p;
        p = (^d) ^ ~par_ok;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s0);
        send_bit(s1);
    endtask

    task automatic send_exp(input logic [7:0] d, input logic par_ok, input logic s0, input logic s1);
        exp_t e;
        e.d  = d;
        e.pe = ~par_ok;
        e.fe = ~(s0 & s1);
        q.push_back(e);
        send_frame(d, par_ok, s0, s1);
    endtask

    initial begin
        rx_readyH = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rx_readyH = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (overrun_errH === 1'b1) ovr_seen++;
                if (rx_validH === 1'b1 && rx_readyH === 1'b1) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got %0h, required no word (t=%0t)", rx_dataH, $time);
                    end else begin
                        e = q.pop_front();
                        chk("rx_data", 32'(rx_dataH), 32'(e.d));
                        chk("parity_err", 32'(parity_errH), 32'(e.pe));
                        chk("frame_err", 32'(frame_errH), 32'(e.fe));
                    end
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL timeout: bench did not complete, queue depth %0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       pok;
        logic       s0;
        logic       s1;
        int         guard;
        rst  = 1'b1;
        line = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(rx_validH), 0);
        chk("reset_data", 32'(rx_dataH), 0);
        chk("reset_busy", 32'(busyH), 0);
        chk("reset_perr", 32'(parity_errH), 0);
        chk("reset_ferr", 32'(frame_errH), 0);
        chk("reset_ovr", 32'(overrun_errH), 0);
        rst = 1'b0;
        idle(1);

        send_exp(8'h43, 1'b1, 1'b1, 1'b1);
        idle(2);
        send_exp(8'h43, 1'b0, 1'b1, 1'b1);
        idle(2);
        send_exp(8'h44, 1'b1, 1'b1, 1'b1);
        idle(6);
        send_exp(8'h45, 1'b1, 1'b1, 1'b1);
        idle(6);
        send_exp(8'h46, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Short low glitch on the idle line
        line = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        line = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("glitch_seen_busy", 32'(busyH), 1);
        repeat (BIT_CYC) @(posedge clk);
        #1;
        chk("glitch_rejected_busy", 32'(busyH), 0);
        idle(1);

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d   = 8'($urandom);
            pok = ($urandom_range(0, 3) != 0);
            s0  = ($urandom_range(0, 7) != 0);
            s1  = ($urandom_range(0, 7) != 0);
            send_exp(d, pok, s0, s1);
            idle($urandom_range(1, 3));
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        idle(2);

        // Bad stop bits followed by a held-low (break) line
        send_exp(8'h5A, 1'b1, 1'b0, 1'b0);
        line = 1'b0;
        repeat (10 * BIT_CYC) @(posedge clk);
        #1;
        chk("break_busy_held", 32'(busyH), 1);
        line = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("break_release_idle", 32'(busyH), 0);
        idle(1);
        send_exp(8'h44, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Overrun: consumer stalled across two frames
        ready_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_exp(8'h43, 1'b1, 1'b1, 1'b1);
        idle(1);
        send_frame(8'h44, 1'b1, 1'b1, 1'b1);
        ovr_exp++;
        idle(1);
        chk("overrun_held_valid", 32'(rx_validH), 1);
        chk("overrun_held_data", 32'(rx_dataH), 32'h43);
        ready_force = 1'b1;
        idle(2);

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("midframe_busy", 32'(busyH), 1);
        rst = 1'b1;
        #1;
        chk("midrst_data", 32'(rx_dataH), 0);
        chk("midrst_valid", 32'(rx_validH), 0);
        chk("midrst_busy", 32'(busyH), 0);
        chk("midrst_flags", 32'({parity_errH, frame_errH, overrun_errH}), 0);
        line = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        send_exp(8'hA5, 1'b1, 1'b1, 1'b1);
        idle(2);

        guard = 0;
        while (q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        chk("overrun_pulse_cycles", 32'(ovr_seen), 32'(ovr_exp));
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
